// File: rtl/axi_priv_filter_pkg.sv
// Shared types for the privilege/address access filter: AXI channel structs
// (local stand-ins for ariane_axi req_t/resp_t), FSM states and region config.
package axi_priv_filter_pkg;

  localparam int unsigned AXI_ID_W     = 4;
  localparam int unsigned AXI_ADDR_W   = 64;
  localparam int unsigned AXI_DATA_W   = 64;
  localparam int unsigned MAX_PRIV_LVL = 16;
  localparam int unsigned PIDX_W       = $clog2(MAX_PRIV_LVL);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DRAIN, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_RESP}          r_state_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } axi_ax_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0]   data;
    logic [AXI_DATA_W/8-1:0] strb;
    logic                    last;
  } axi_w_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
  } axi_b_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   r_valid;
    axi_r_t r;
  } axi_resp_t;

  // Fields are sized for the widest supported config; narrower ports zero-extend.
  typedef struct packed {
    logic [AXI_ADDR_W-1:0]   start_addr;
    logic [AXI_ADDR_W-1:0]   end_addr;
    logic [MAX_PRIV_LVL-1:0] rd_en;
    logic [MAX_PRIV_LVL-1:0] wr_en;
  } region_cfg_t;

endpackage

// File: rtl/axi_priv_region_decode.sv
// Combinational window hit + permission check for one address channel.
module axi_priv_region_decode
  import axi_priv_filter_pkg::*;
#(
  parameter int unsigned NB_REGION      = 8,
  parameter int unsigned NB_PRIV_LVL    = 4,
  parameter int unsigned PRIV_LVL_WIDTH = 2
) (
  input  region_cfg_t [NB_REGION-1:0] cfg_i,
  input  logic [AXI_ADDR_W-1:0]       addr_i,
  input  logic [PRIV_LVL_WIDTH-1:0]   priv_i,
  input  logic                        is_write_i,
  output logic                        allow_o
);

  logic [PIDX_W-1:0] pidx;

  always_comb begin
    allow_o = 1'b0;
    pidx    = PIDX_W'(priv_i);
    if (32'(priv_i) < NB_PRIV_LVL) begin
      for (int unsigned r = 0; r < NB_REGION; r++) begin
        if ((addr_i >= cfg_i[r].start_addr) && (addr_i <= cfg_i[r].end_addr)) begin
          if (is_write_i ? cfg_i[r].wr_en[pidx] : cfg_i[r].rd_en[pidx]) begin
            allow_o = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/axi_priv_access_filter.sv
// Per-port AXI privilege/address filter: permitted AW/AR pass through with zero
// latency, denied ones are terminated locally with DECERR and logged.
module axi_priv_access_filter
  import axi_priv_filter_pkg::*;
#(
  parameter int unsigned NB_REGION      = 8,
  parameter int unsigned NB_PRIV_LVL    = 4,
  parameter int unsigned PRIV_LVL_WIDTH = $clog2(NB_PRIV_LVL),
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned MAX_TXN        = 8,
  parameter type         req_t          = axi_req_t,
  parameter type         resp_t         = axi_resp_t
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  req_t                                         slv_req_i,
  output resp_t                                        slv_resp_o,
  output req_t                                         mst_req_o,
  input  resp_t                                        mst_resp_i,
  input  logic [PRIV_LVL_WIDTH-1:0]                    priv_lvl_i,
  input  logic [NB_REGION-1:0][AXI_ADDR_WIDTH-1:0]     start_addr_i,
  input  logic [NB_REGION-1:0][AXI_ADDR_WIDTH-1:0]     end_addr_i,
  input  logic [NB_REGION-1:0][NB_PRIV_LVL-1:0]        rd_en_i,
  input  logic [NB_REGION-1:0][NB_PRIV_LVL-1:0]        wr_en_i,
  input  logic                                         err_clr_i,
  output logic                                         err_valid_o,
  output logic [AXI_ADDR_WIDTH-1:0]                    err_addr_o,
  output logic                                         err_write_o,
  output logic [15:0]                                  err_cnt_o
);

  localparam int unsigned CNT_W = $clog2(MAX_TXN + 1);

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic [CNT_W-1:0]          wr_out_q, wr_out_d, rd_out_q, rd_out_d;
  logic [AXI_ID_W-1:0]       bid_q, bid_d, rid_q, rid_d;
  logic [7:0]                rlen_q, rlen_d, rbeat_q, rbeat_d;
  logic                      err_valid_q, err_valid_d, err_write_q, err_write_d;
  logic [AXI_ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic [15:0]               err_cnt_q, err_cnt_d;
  logic [16:0]               err_cnt_sum;

  region_cfg_t [NB_REGION-1:0] cfg;
  logic aw_allow, ar_allow, wr_full, rd_full;
  logic aw_deny_hs, ar_deny_hs, mst_aw_hs, mst_ar_hs, mst_b_hs, mst_rlast_hs;

  always_comb begin
    for (int unsigned r = 0; r < NB_REGION; r++) begin
      cfg[r].start_addr = AXI_ADDR_W'(start_addr_i[r]);
      cfg[r].end_addr   = AXI_ADDR_W'(end_addr_i[r]);
      cfg[r].rd_en      = MAX_PRIV_LVL'(rd_en_i[r]);
      cfg[r].wr_en      = MAX_PRIV_LVL'(wr_en_i[r]);
    end
  end

  axi_priv_region_decode #(
    .NB_REGION      (NB_REGION),
    .NB_PRIV_LVL    (NB_PRIV_LVL),
    .PRIV_LVL_WIDTH (PRIV_LVL_WIDTH)
  ) u_aw_decode (
    .cfg_i      (cfg),
    .addr_i     (AXI_ADDR_W'(slv_req_i.aw.addr[AXI_ADDR_WIDTH-1:0])),
    .priv_i     (priv_lvl_i),
    .is_write_i (1'b1),
    .allow_o    (aw_allow)
  );

  axi_priv_region_decode #(
    .NB_REGION      (NB_REGION),
    .NB_PRIV_LVL    (NB_PRIV_LVL),
    .PRIV_LVL_WIDTH (PRIV_LVL_WIDTH)
  ) u_ar_decode (
    .cfg_i      (cfg),
    .addr_i     (AXI_ADDR_W'(slv_req_i.ar.addr[AXI_ADDR_WIDTH-1:0])),
    .priv_i     (priv_lvl_i),
    .is_write_i (1'b0),
    .allow_o    (ar_allow)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_q   <= W_IDLE;
      r_state_q   <= R_IDLE;
      wr_out_q    <= '0;
      rd_out_q    <= '0;
      bid_q       <= '0;
      rid_q       <= '0;
      rlen_q      <= '0;
      rbeat_q     <= '0;
      err_valid_q <= 1'b0;
      err_write_q <= 1'b0;
      err_addr_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      w_state_q   <= w_state_d;
      r_state_q   <= r_state_d;
      wr_out_q    <= wr_out_d;
      rd_out_q    <= rd_out_d;
      bid_q       <= bid_d;
      rid_q       <= rid_d;
      rlen_q      <= rlen_d;
      rbeat_q     <= rbeat_d;
      err_valid_q <= err_valid_d;
      err_write_q <= err_write_d;
      err_addr_q  <= err_addr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Outputs: pass-through by default, then gate/override per FSM state.
  always_comb begin
    mst_req_o  = slv_req_i;
    slv_resp_o = mst_resp_i;
    wr_full    = (32'(wr_out_q) >= MAX_TXN);
    rd_full    = (32'(rd_out_q) >= MAX_TXN);

    mst_req_o.aw_valid  = 1'b0;
    slv_resp_o.aw_ready = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_allow) begin
          mst_req_o.aw_valid  = slv_req_i.aw_valid & ~wr_full;
          slv_resp_o.aw_ready = mst_resp_i.aw_ready & ~wr_full;
        end else begin
          slv_resp_o.aw_ready = (wr_out_q == '0);
        end
      end
      W_DRAIN: begin
        mst_req_o.w_valid  = 1'b0;
        slv_resp_o.w_ready = 1'b1;
      end
      W_RESP: begin
        mst_req_o.w_valid  = 1'b0;
        slv_resp_o.w_ready = 1'b0;
        mst_req_o.b_ready  = 1'b0;
        slv_resp_o.b_valid = 1'b1;
        slv_resp_o.b.id    = bid_q;
        slv_resp_o.b.resp  = RESP_DECERR;
      end
      default: ;
    endcase

    mst_req_o.ar_valid  = 1'b0;
    slv_resp_o.ar_ready = 1'b0;
    if (r_state_q == R_IDLE) begin
      if (ar_allow) begin
        mst_req_o.ar_valid  = slv_req_i.ar_valid & ~rd_full;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & ~rd_full;
      end else begin
        slv_resp_o.ar_ready = (rd_out_q == '0);
      end
    end else begin
      mst_req_o.r_ready  = 1'b0;
      slv_resp_o.r_valid = 1'b1;
      slv_resp_o.r       = '0;
      slv_resp_o.r.id    = rid_q;
      slv_resp_o.r.resp  = RESP_DECERR;
      slv_resp_o.r.last  = (rbeat_q == rlen_q);
    end
  end

  always_comb begin
    mst_aw_hs    = mst_req_o.aw_valid & mst_resp_i.aw_ready;
    mst_ar_hs    = mst_req_o.ar_valid & mst_resp_i.ar_ready;
    mst_b_hs     = mst_resp_i.b_valid & mst_req_o.b_ready;
    mst_rlast_hs = mst_resp_i.r_valid & mst_req_o.r_ready & mst_resp_i.r.last;
    aw_deny_hs   = (w_state_q == W_IDLE) & ~aw_allow & slv_req_i.aw_valid & slv_resp_o.aw_ready;
    ar_deny_hs   = (r_state_q == R_IDLE) & ~ar_allow & slv_req_i.ar_valid & slv_resp_o.ar_ready;

    w_state_d = w_state_q;
    r_state_d = r_state_q;
    bid_d     = bid_q;
    rid_d     = rid_q;
    rlen_d    = rlen_q;
    rbeat_d   = rbeat_q;
    wr_out_d  = wr_out_q + CNT_W'(mst_aw_hs) - CNT_W'(mst_b_hs);
    rd_out_d  = rd_out_q + CNT_W'(mst_ar_hs) - CNT_W'(mst_rlast_hs);

    case (w_state_q)
      W_IDLE: if (aw_deny_hs) begin
        bid_d     = slv_req_i.aw.id;
        w_state_d = W_DRAIN;
      end
      W_DRAIN: if (slv_req_i.w_valid && slv_req_i.w.last) w_state_d = W_RESP;
      W_RESP:  if (slv_req_i.b_ready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase

    if (r_state_q == R_IDLE) begin
      if (ar_deny_hs) begin
        rid_d     = slv_req_i.ar.id;
        rlen_d    = slv_req_i.ar.len;
        rbeat_d   = '0;
        r_state_d = R_RESP;
      end
    end else if (slv_req_i.r_ready) begin
      if (rbeat_q == rlen_q) r_state_d = R_IDLE;
      else                   rbeat_d   = rbeat_q + 8'd1;
    end

    // Clear beats any same-cycle denial; the write side wins first capture.
    err_valid_d = err_valid_q;
    err_write_d = err_write_q;
    err_addr_d  = err_addr_q;
    err_cnt_sum = {1'b0, err_cnt_q} + 17'(aw_deny_hs) + 17'(ar_deny_hs);
    err_cnt_d   = err_cnt_sum[16] ? 16'hFFFF : err_cnt_sum[15:0];
    if (err_clr_i) begin
      err_valid_d = 1'b0;
      err_write_d = 1'b0;
      err_addr_d  = '0;
      err_cnt_d   = '0;
    end else if (!err_valid_q && (aw_deny_hs || ar_deny_hs)) begin
      err_valid_d = 1'b1;
      err_write_d = aw_deny_hs;
      err_addr_d  = aw_deny_hs ? slv_req_i.aw.addr[AXI_ADDR_WIDTH-1:0]
                               : slv_req_i.ar.addr[AXI_ADDR_WIDTH-1:0];
    end
  end

  assign err_valid_o = err_valid_q;
  assign err_write_o = err_write_q;
  assign err_addr_o  = err_addr_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_axi_priv_access_filter.sv
// Directed self-checking bench for axi_priv_access_filter.
module tb_axi_priv_access_filter;
  import axi_priv_filter_pkg::*;

  localparam int unsigned NB_REGION   = 8;
  localparam int unsigned NB_PRIV_LVL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, err_clr, err_valid, err_write;
  logic [1:0] priv;
  logic [63:0] err_addr;
  logic [15:0] err_cnt;
  axi_req_t  slv_req, mst_req;
  axi_resp_t slv_resp, mst_resp;
  logic [NB_REGION-1:0][63:0] start_addr, end_addr;
  logic [NB_REGION-1:0][NB_PRIV_LVL-1:0] rd_en, wr_en;

  int n_checks = 0;
  int n_fail   = 0;
  int beats;

  axi_priv_access_filter #(
    .NB_REGION      (NB_REGION),
    .NB_PRIV_LVL    (NB_PRIV_LVL),
    .PRIV_LVL_WIDTH (2),
    .AXI_ADDR_WIDTH (64),
    .MAX_TXN        (8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .slv_req_i    (slv_req),
    .slv_resp_o   (slv_resp),
    .mst_req_o    (mst_req),
    .mst_resp_i   (mst_resp),
    .priv_lvl_i   (priv),
    .start_addr_i (start_addr),
    .end_addr_i   (end_addr),
    .rd_en_i      (rd_en),
    .wr_en_i      (wr_en),
    .err_clr_i    (err_clr),
    .err_valid_o  (err_valid),
    .err_addr_o   (err_addr),
    .err_write_o  (err_write),
    .err_cnt_o    (err_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; err_clr = 1'b0; priv = 2'd1;
    slv_req = '0; mst_resp = '0;
    start_addr = '1; end_addr = '0; rd_en = '0; wr_en = '0;
    start_addr[0] = 64'h1000; end_addr[0] = 64'h1FFF;
    wr_en[0][1] = 1'b1; rd_en[0][1] = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_err_valid", 64'(err_valid), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_err_addr", err_addr, 64'd0);
    check("rst_err_write", 64'(err_write), 64'd0);
    check("rst_bvalid", 64'(slv_resp.b_valid), 64'd0);
    check("rst_rvalid", 64'(slv_resp.r_valid), 64'd0);
    check("rst_mst_awvalid", 64'(mst_req.aw_valid), 64'd0);
    check("rst_mst_arvalid", 64'(mst_req.ar_valid), 64'd0);
    check("rst_mst_wvalid", 64'(mst_req.w_valid), 64'd0);

    // Permitted write forwarded with zero added latency.
    slv_req.aw.id = 4'd3; slv_req.aw.addr = 64'h1800; slv_req.aw.len = 8'd3;
    slv_req.aw_valid = 1'b1; mst_resp.aw_ready = 1'b1;
    #1;
    check("ok_mst_awvalid", 64'(mst_req.aw_valid), 64'd1);
    check("ok_awready", 64'(slv_resp.aw_ready), 64'd1);
    check("ok_mst_awaddr", mst_req.aw.addr, 64'h1800);
    step();
    slv_req.aw_valid = 1'b0; mst_resp.w_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      slv_req.w_valid = 1'b1; slv_req.w.data = 64'(i + 16'hA0); slv_req.w.last = (i == 3);
      #1;
      check("ok_mst_wvalid", 64'(mst_req.w_valid), 64'd1);
      check("ok_mst_wdata", mst_req.w.data, 64'(i + 16'hA0));
      step();
    end
    slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0; mst_resp.w_ready = 1'b0;
    mst_resp.b_valid = 1'b1; mst_resp.b.id = 4'd3; mst_resp.b.resp = RESP_OKAY; slv_req.b_ready = 1'b1;
    #1;
    check("ok_bvalid", 64'(slv_resp.b_valid), 64'd1);
    check("ok_bresp", 64'(slv_resp.b.resp), 64'd0);
    check("ok_bid", 64'(slv_resp.b.id), 64'd3);
    step();
    mst_resp.b_valid = 1'b0; slv_req.b_ready = 1'b0;
    #1;
    check("ok_err_cnt", 64'(err_cnt), 64'd0);
    check("ok_err_valid", 64'(err_valid), 64'd0);

    // Denied write (priv 0): W absorbed, local DECERR.
    priv = 2'd0; slv_req.aw.id = 4'd5; slv_req.aw_valid = 1'b1;
    #1;
    check("dw_mst_awvalid", 64'(mst_req.aw_valid), 64'd0);
    check("dw_awready", 64'(slv_resp.aw_ready), 64'd1);
    step();
    slv_req.aw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      slv_req.w_valid = 1'b1; slv_req.w.last = (i == 3);
      #1;
      check("dw_wready", 64'(slv_resp.w_ready), 64'd1);
      check("dw_mst_wvalid", 64'(mst_req.w_valid), 64'd0);
      check("dw_no_early_b", 64'(slv_resp.b_valid), 64'd0);
      step();
    end
    slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0;
    #1;
    check("dw_bvalid", 64'(slv_resp.b_valid), 64'd1);
    check("dw_bresp", 64'(slv_resp.b.resp), 64'd3);
    check("dw_bid", 64'(slv_resp.b.id), 64'd5);
    check("dw_err_valid", 64'(err_valid), 64'd1);
    check("dw_err_addr", err_addr, 64'h1800);
    check("dw_err_write", 64'(err_write), 64'd1);
    check("dw_err_cnt", 64'(err_cnt), 64'd1);
    step();
    check("dw_bvalid_hold", 64'(slv_resp.b_valid), 64'd1);
    check("dw_bid_hold", 64'(slv_resp.b.id), 64'd5);
    slv_req.b_ready = 1'b1;
    step();
    slv_req.b_ready = 1'b0;
    #1;
    check("dw_bvalid_done", 64'(slv_resp.b_valid), 64'd0);

    // Denied read (no hit), rready toggling.
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    #1;
    check("clr_err_cnt", 64'(err_cnt), 64'd0);
    check("clr_err_valid", 64'(err_valid), 64'd0);
    priv = 2'd1;
    slv_req.ar.id = 4'd6; slv_req.ar.addr = 64'h9000; slv_req.ar.len = 8'd7; slv_req.ar_valid = 1'b1;
    #1;
    check("dr_arready", 64'(slv_resp.ar_ready), 64'd1);
    check("dr_mst_arvalid", 64'(mst_req.ar_valid), 64'd0);
    step();
    slv_req.ar_valid = 1'b0;
    check("dr_first_rvalid", 64'(slv_resp.r_valid), 64'd1);
    beats = 0;
    for (int c = 0; c < 40 && beats < 8; c++) begin
      slv_req.r_ready = c[0];
      #1;
      if (slv_resp.r_valid && slv_req.r_ready) begin
        check("dr_rresp", 64'(slv_resp.r.resp), 64'd3);
        check("dr_rid", 64'(slv_resp.r.id), 64'd6);
        check("dr_rdata", slv_resp.r.data, 64'd0);
        check("dr_rlast", 64'(slv_resp.r.last), 64'(beats == 7));
        beats++;
      end
      step();
    end
    slv_req.r_ready = 1'b0;
    #1;
    check("dr_beats", 64'(beats), 64'd8);
    check("dr_rvalid_done", 64'(slv_resp.r_valid), 64'd0);
    check("dr_err_cnt", 64'(err_cnt), 64'd1);
    check("dr_err_write", 64'(err_write), 64'd0);
    check("dr_err_addr", err_addr, 64'h9000);

    // MAX_TXN outstanding writes, then a stalled AW and a held denied AW.
    mst_resp.aw_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      slv_req.aw.id = 4'(i); slv_req.aw.addr = 64'h1000 + 64'(i * 16); slv_req.aw_valid = 1'b1;
      #1;
      check("mx_awready", 64'(slv_resp.aw_ready), 64'd1);
      step();
    end
    #1;
    check("mx_full_awready", 64'(slv_resp.aw_ready), 64'd0);
    check("mx_full_mst_awvalid", 64'(mst_req.aw_valid), 64'd0);
    step();
    check("mx_full_awready2", 64'(slv_resp.aw_ready), 64'd0);
    mst_resp.b_valid = 1'b1; slv_req.b_ready = 1'b1;
    step();
    mst_resp.b_valid = 1'b0;
    #1;
    check("mx_after_b_awready", 64'(slv_resp.aw_ready), 64'd1);
    check("mx_after_b_mst_awvalid", 64'(mst_req.aw_valid), 64'd1);
    step();
    priv = 2'd0; slv_req.aw.id = 4'd9; slv_req.aw.addr = 64'h1800;
    for (int i = 0; i < 8; i++) begin
      mst_resp.b_valid = 1'b1;
      #1;
      check("mx_deny_held", 64'(slv_resp.aw_ready), 64'd0);
      step();
    end
    mst_resp.b_valid = 1'b0;
    #1;
    check("mx_deny_accept", 64'(slv_resp.aw_ready), 64'd1);
    check("mx_deny_mst_awvalid", 64'(mst_req.aw_valid), 64'd0);
    step();
    slv_req.aw_valid = 1'b0; slv_req.b_ready = 1'b0;
    slv_req.w_valid = 1'b1; slv_req.w.last = 1'b1;
    step();
    slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0; slv_req.b_ready = 1'b1;
    #1;
    check("mx_deny_bresp", 64'(slv_resp.b.resp), 64'd3);
    check("mx_deny_bid", 64'(slv_resp.b.id), 64'd9);
    step();
    slv_req.b_ready = 1'b0; mst_resp.aw_ready = 1'b0;
    check("mx_err_cnt", 64'(err_cnt), 64'd2);
    check("mx_err_addr_first", err_addr, 64'h9000);
    check("mx_err_write_first", 64'(err_write), 64'd0);

    // Counter saturation with continuous AW + AR denials.
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    priv = 2'd0;
    slv_req.aw.addr = 64'h1800; slv_req.aw.id = 4'd1; slv_req.aw.len = 8'd0;
    slv_req.ar.addr = 64'h9000; slv_req.ar.id = 4'd2; slv_req.ar.len = 8'd0;
    slv_req.aw_valid = 1'b1; slv_req.ar_valid = 1'b1;
    slv_req.w_valid = 1'b1; slv_req.w.last = 1'b1; slv_req.b_ready = 1'b1; slv_req.r_ready = 1'b1;
    step();
    check("sat_dual_cnt", 64'(err_cnt), 64'd2);
    check("sat_dual_write", 64'(err_write), 64'd1);
    check("sat_dual_addr", err_addr, 64'h1800);
    repeat (78659) step();
    check("sat_cnt", 64'(err_cnt), 64'hFFFF);
    check("sat_valid", 64'(err_valid), 64'd1);
    check("sat_addr", err_addr, 64'h1800);
    slv_req.aw_valid = 1'b0; slv_req.ar_valid = 1'b0;
    repeat (4) step();
    slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0; slv_req.b_ready = 1'b0;
    slv_req.ar_valid = 1'b1; err_clr = 1'b1;
    #1;
    check("clr_deny_arready", 64'(slv_resp.ar_ready), 64'd1);
    step();
    slv_req.ar_valid = 1'b0; err_clr = 1'b0;
    #1;
    check("clr_pri_valid", 64'(err_valid), 64'd0);
    check("clr_pri_cnt", 64'(err_cnt), 64'd0);
    check("clr_pri_addr", err_addr, 64'd0);
    check("clr_pri_write", 64'(err_write), 64'd0);
    step();
    slv_req.r_ready = 1'b0;

    // Reset in the middle of a local read burst.
    slv_req.ar.len = 8'd7; slv_req.ar.id = 4'd4; slv_req.ar_valid = 1'b1;
    step();
    slv_req.ar_valid = 1'b0; slv_req.r_ready = 1'b1;
    step(); step();
    slv_req.r_ready = 1'b0;
    #1;
    check("mr_pre_rvalid", 64'(slv_resp.r_valid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("mr_rvalid", 64'(slv_resp.r_valid), 64'd0);
    check("mr_err_cnt", 64'(err_cnt), 64'd0);
    priv = 2'd1;
    slv_req.ar.addr = 64'h1400; slv_req.ar.id = 4'd2; slv_req.ar.len = 8'd0; slv_req.ar_valid = 1'b1;
    mst_resp.ar_ready = 1'b1;
    #1;
    check("mr_mst_arvalid", 64'(mst_req.ar_valid), 64'd1);
    check("mr_arready", 64'(slv_resp.ar_ready), 64'd1);
    check("mr_mst_araddr", mst_req.ar.addr, 64'h1400);
    step();
    slv_req.ar_valid = 1'b0; mst_resp.ar_ready = 1'b0;
    mst_resp.r_valid = 1'b1; mst_resp.r.id = 4'd2; mst_resp.r.data = 64'hABCD;
    mst_resp.r.resp = RESP_OKAY; mst_resp.r.last = 1'b1; slv_req.r_ready = 1'b1;
    #1;
    check("mr_rvalid_fwd", 64'(slv_resp.r_valid), 64'd1);
    check("mr_rdata_fwd", slv_resp.r.data, 64'hABCD);
    check("mr_rresp_fwd", 64'(slv_resp.r.resp), 64'd0);
    check("mr_mst_rready", 64'(mst_req.r_ready), 64'd1);
    step();
    mst_resp.r_valid = 1'b0; slv_req.r_ready = 1'b0;
    #1;
    check("mr_final_err_cnt", 64'(err_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_priv_access_filter.md
# axi_priv_access_filter

Parametrised, registered successor to the per-port privilege/address access control in the DAC19 AXI interconnect. It sits between one upstream AXI manager port (core or debug) and one crossbar subordinate port. It checks every AW/AR against NB_REGION address windows with separate read and write permission masks per privilege level. Allowed transactions pass through; denied ones are terminated locally with DECERR and logged.

## Interface
- NB_REGION, 8, number of address windows
- NB_PRIV_LVL, 4, number of privilege levels
- PRIV_LVL_WIDTH, $clog2(NB_PRIV_LVL), width of priv_lvl_i
- AXI_ADDR_WIDTH, 64, address width
- MAX_TXN, 8, maximum outstanding allowed transactions per direction
- req_t / resp_t, ariane_axi::req_t / resp_t, AXI channel structs
- clk_i  in  1  clock; one clock domain
- rst_i  in  1  reset, synchronous, active-high
- slv_req_i / slv_resp_o  in/out  req_t/resp_t  upstream manager side
- mst_req_o / mst_resp_i  out/in  req_t/resp_t  crossbar side
- priv_lvl_i  in  PRIV_LVL_WIDTH  current privilege, sampled at AW/AR handshake
- start_addr_i / end_addr_i  in  NB_REGION x AXI_ADDR_WIDTH  inclusive window bounds
- rd_en_i / wr_en_i  in  NB_REGION x NB_PRIV_LVL  permission bits
- err_clr_i  in  1  clears error log and counter
- err_valid_o  out  1  sticky: at least one denial logged
- err_addr_o  out  AXI_ADDR_WIDTH  address of first denial since clear
- err_write_o  out  1  first denial was a write
- err_cnt_o  out  16  saturating denial count

## Operation
- Decode: region r hits when start[r] <= addr <= end[r]. Permitted when any hit region has rd_en/wr_en[r][priv_lvl_i] set. No hit means denied. priv_lvl_i >= NB_PRIV_LVL means denied.
- Write FSM states:
  - W_IDLE: a permitted AW passes combinationally to mst when wr_out < MAX_TXN, else it stalls (awready=0). W beats and B pass through. A denied AW is held (awready=0) until wr_out==0, then accepted locally. Latch awid, then go to W_DRAIN.
  - W_DRAIN: wready=1 to slv; mst W valid forced 0; beats discarded. On the wlast handshake go to W_RESP.
  - W_RESP: slv B valid=1, bresp=2'b11, bid=latched id. On bready go to W_IDLE.
  - New AWs stall outside W_IDLE.
- Read FSM states:
  - R_IDLE: same rule using rd_out and AR/R. A denied AR is accepted once rd_out==0. Latch arid and arlen, then go to R_RESP.
  - R_RESP: emit arlen+1 beats with rresp=2'b11, rdata=0, rid=latched id, and rlast on the final beat. The beat counter advances only on rready. After the last beat go to R_IDLE.
- Outstanding counters wr_out/rd_out (width $clog2(MAX_TXN+1)):
  - +1 on a mst AW/AR handshake.
  - −1 on a mst B handshake, or on an R handshake with rlast.
  - Simultaneous +1/−1 leaves the count unchanged.
- Waiting for zero outstanding keeps per-ID ordering legal with no reorder buffer.
- Error log:
  - On each denied AW/AR handshake, err_cnt_o increments, saturating at 16'hFFFF.
  - On the first denial only, set err_valid_o and capture err_addr_o/err_write_o.
  - A simultaneous AW and AR denial counts +2; the write wins the capture.
  - err_clr_i has priority over any same-cycle denial, which is dropped.

## Timing
- Reset values:
  - All FSMs IDLE, counters 0.
  - err_valid_o=0, err_addr_o=0, err_write_o=0, err_cnt_o=0.
  - slv B/R valid=0, mst AW/AR/W valid=0.
- Reset mid-burst abandons local responses immediately.
- Allowed path adds zero cycles; all gating is combinational on registered state.
- Denied write: B valid appears the cycle after the wlast handshake.
- Denied read: first R valid appears the cycle after the AR handshake. One beat per cycle under continuous rready.
- Once asserted, local valids hold with stable payload until the handshake.
- Error outputs update the cycle after the triggering handshake.

## Structure
- axi_priv_filter_pkg holds:
  - w_state_e / r_state_e enums
  - RESP_DECERR constant
  - region_cfg_t struct (start, end, rd_en, wr_en)
- Sub-module axi_priv_region_decode: combinational hit/permission check for (addr, priv, is_write). It is instantiated twice, once for AW and once for AR.

## Test plan
- Region0 0x1000–0x1FFF, wr_en[0][1]=1, priv=1, AW 0x1800 len=3 -> forwarded; 4 W beats reach mst; mst OKAY B returned; err_cnt_o=0.
- Same config, priv=0, AW 0x1800 len=3 -> 4 W beats absorbed; B DECERR with the matching id one cycle after wlast; err_valid_o=1, err_addr_o=0x1800, err_write_o=1.
- AR 0x9000 (no hit) arlen=7, rready toggling -> exactly 8 DECERR beats; rlast only on the 8th; err_cnt_o=1.
- MAX_TXN allowed writes outstanding, then a further AW -> awready=0 until a B returns. A denied AW is held until wr_out==0.
- 65540 denials -> err_cnt_o=16'hFFFF; err_clr_i raised in the same cycle as a denial -> all error outputs 0.
- rst_i in the middle of R_RESP -> R valid=0 next cycle; FSM idle; the next permitted AR forwards normally.
